// File: rtl/instr_mem_loader.sv
// instr_mem_loader: collects a big-endian byte stream into 32-bit words and
// writes them to the instruction RAM from word 0 upward, holding the core
// while a load is in progress.
module instr_mem_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Start,
  input  logic [ADDR_WIDTH:0]   WordCount,
  input  logic                  ByteValid,
  input  logic [7:0]            ByteData,
  output logic                  ByteReady,
  output logic                  MemWrEn,
  output logic [31:0]           MemAddress,
  output logic [31:0]           MemWrData,
  output logic                  CpuHold,
  output logic                  Done,
  output logic                  Error
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RECV  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Largest legal WordCount is a full RAM; anything above is rejected.
  localparam logic [ADDR_WIDTH:0]   MAX_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   CNT_ZERO  = {(ADDR_WIDTH+1){1'b0}};
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] IDX_ZERO  = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] IDX_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_t                r_state;
  state_t                w_next_state;
  logic [ADDR_WIDTH-1:0] r_index;
  logic [ADDR_WIDTH:0]   r_count;
  logic [1:0]            r_byte_cnt;
  logic [31:0]           r_shift;
  logic                  r_error;

  logic w_ready;
  logic w_xfer;
  logic w_zero_req;
  logic w_too_big;
  logic w_accept;
  logic w_last;

  assign w_ready    = (r_state == S_RECV);
  assign w_xfer     = ByteValid && w_ready;
  assign w_zero_req = (WordCount == CNT_ZERO);
  assign w_too_big  = (WordCount > MAX_WORDS);
  assign w_accept   = (r_state == S_IDLE) && Start && !w_zero_req && !w_too_big;
  // Compare against the latched count so a busy-time Start cannot shorten a load.
  assign w_last     = ({1'b0, r_index} == (r_count - CNT_ONE));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (Start && w_zero_req) begin
          w_next_state = S_DONE;
        end else if (Start && !w_too_big) begin
          w_next_state = S_RECV;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_RECV: begin
        if (w_xfer && (r_byte_cnt == 2'd3)) begin
          w_next_state = S_WRITE;
        end else begin
          w_next_state = S_RECV;
        end
      end
      S_WRITE: begin
        if (w_last) begin
          w_next_state = S_DONE;
        end else begin
          w_next_state = S_RECV;
        end
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Datapath: word count latch, word index, byte assembly and error pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_index    <= IDX_ZERO;
      r_count    <= CNT_ZERO;
      r_byte_cnt <= 2'd0;
      r_shift    <= 32'd0;
      r_error    <= 1'b0;
    end else begin
      r_error <= (r_state == S_IDLE) && Start && w_too_big;
      if (w_accept) begin
        r_count    <= WordCount;
        r_index    <= IDX_ZERO;
        r_byte_cnt <= 2'd0;
      end
      if (w_xfer) begin
        r_shift    <= {r_shift[23:0], ByteData};
        // Two-bit counter returns to 0 on the fourth byte of each word.
        r_byte_cnt <= r_byte_cnt + 2'd1;
      end
      // Index stops at the final word instead of wrapping.
      if ((r_state == S_WRITE) && !w_last) begin
        r_index <= r_index + IDX_ONE;
      end
    end
  end

  // Outputs decoded from registered state; write bus is zero outside WRITE.
  always_comb begin
    ByteReady  = w_ready;
    MemWrEn    = 1'b0;
    MemAddress = 32'd0;
    MemWrData  = 32'd0;
    CpuHold    = (r_state != S_IDLE);
    Done       = (r_state == S_DONE);
    Error      = r_error;
    if (r_state == S_WRITE) begin
      MemWrEn    = 1'b1;
      MemAddress = {{(30-ADDR_WIDTH){1'b0}}, r_index, 2'b00};
      MemWrData  = r_shift;
    end else begin
      MemWrEn    = 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: one instance at ADDR_WIDTH=8 and one
// at ADDR_WIDTH=2 for the full-RAM wrap case.
module tb_instr_mem_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        start = 1'b0;
  logic [8:0]  word_count = 9'd0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'd0;
  logic        byte_ready, mem_wr_en, cpu_hold, done, error;
  logic [31:0] mem_address, mem_wr_data;

  logic        d2_start = 1'b0;
  logic [2:0]  d2_word_count = 3'd0;
  logic        d2_valid = 1'b0;
  logic [7:0]  d2_data = 8'd0;
  logic        d2_ready, d2_wr_en, d2_hold, d2_done, d2_error;
  logic [31:0] d2_address, d2_wr_data;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [63:0] q1[$];
  logic [63:0] q2[$];
  int wr_cnt1 = 0;
  int wr_cnt2 = 0;
  int last_wr_cyc = -1;
  bit check_gap = 1'b0;
  bit loading = 1'b0;
  logic [31:0] words[0:3];

  instr_mem_loader #(.ADDR_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .Start(start), .WordCount(word_count),
    .ByteValid(byte_valid), .ByteData(byte_data), .ByteReady(byte_ready),
    .MemWrEn(mem_wr_en), .MemAddress(mem_address), .MemWrData(mem_wr_data),
    .CpuHold(cpu_hold), .Done(done), .Error(error)
  );

  instr_mem_loader #(.ADDR_WIDTH(2)) dut2 (
    .clk(clk), .reset(reset), .Start(d2_start), .WordCount(d2_word_count),
    .ByteValid(d2_valid), .ByteData(d2_data), .ByteReady(d2_ready),
    .MemWrEn(d2_wr_en), .MemAddress(d2_address), .MemWrData(d2_wr_data),
    .CpuHold(d2_hold), .Done(d2_done), .Error(d2_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Monitor for the 8-bit instance: scoreboard pop, write spacing, idle bus.
  always @(negedge clk) begin
    if (!reset) begin
      if (mem_wr_en) begin
        wr_cnt1++;
        if (q1.size() == 0) begin
          check("sb1_underflow", 32'(q1.size()), 32'd1);
        end else begin
          logic [63:0] e;
          e = q1.pop_front();
          check("wr1_addr", mem_address, e[63:32]);
          check("wr1_data", mem_wr_data, e[31:0]);
        end
        check("wr1_hold", 32'(cpu_hold), 32'd1);
        if (check_gap && last_wr_cyc >= 0)
          check("wr1_gap", 32'(cyc - last_wr_cyc), 32'd5);
        last_wr_cyc = cyc;
      end else begin
        check("idle1_addr", mem_address, 32'd0);
        check("idle1_data", mem_wr_data, 32'd0);
      end
      if (loading) check("hold1_load", 32'(cpu_hold), 32'd1);
    end
  end

  // Monitor for the 2-bit instance.
  always @(negedge clk) begin
    if (!reset && d2_wr_en) begin
      wr_cnt2++;
      if (q2.size() == 0) begin
        check("sb2_underflow", 32'(q2.size()), 32'd1);
      end else begin
        logic [63:0] e;
        e = q2.pop_front();
        check("wr2_addr", d2_address, e[63:32]);
        check("wr2_data", d2_wr_data, e[31:0]);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the byte transferred.
  task automatic send_byte(input int which, input logic [7:0] b, input int gap,
                           input bit push, input logic [63:0] exp);
    int n;
    for (int i = 0; i < gap; i++) begin
      if (which == 1) byte_valid = 1'b0; else d2_valid = 1'b0;
      @(negedge clk);
    end
    if (which == 1) begin byte_valid = 1'b1; byte_data = b; end
    else begin d2_valid = 1'b1; d2_data = b; end
    n = 0;
    while (((which == 1) ? byte_ready : d2_ready) != 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("byte_ready_timeout", 32'(n), 32'd0);
    @(posedge clk);
    if (push) begin
      if (which == 1) q1.push_back(exp); else q2.push_back(exp);
    end
    @(negedge clk);
    if (which == 1) byte_valid = 1'b0; else d2_valid = 1'b0;
  endtask

  task automatic pulse_start(input int which, input int n);
    if (which == 1) begin start = 1'b1; word_count = 9'(n); end
    else begin d2_start = 1'b1; d2_word_count = 3'(n); end
    @(negedge clk);
    if (which == 1) start = 1'b0; else d2_start = 1'b0;
  endtask

  task automatic wait_done(input int which, input string tag);
    int n;
    n = 0;
    while (((which == 1) ? done : d2_done) != 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, 32'((which == 1) ? done : d2_done), 32'd1);
    loading = 1'b0;
  endtask

  task automatic run_load(input int which, input int n, input int gap, input bit mid_start);
    pulse_start(which, n);
    if (which == 1) loading = 1'b1;
    for (int w = 0; w < n; w++) begin
      for (int b = 0; b < 4; b++) begin
        logic [31:0] wd;
        wd = words[w];
        send_byte(which, wd[31-8*b -: 8], gap, (b == 3), {32'(w * 4), wd});
        if (mid_start && w == 1 && b == 1) pulse_start(which, 1);
      end
    end
  endtask

  initial begin
    words[0] = 32'h08000003;
    words[1] = 32'h08000008;
    words[2] = 32'h08000009;
    words[3] = 32'hDEADBEEF;

    repeat (3) @(negedge clk);
    check("rst_wren", 32'(mem_wr_en), 32'd0);
    check("rst_ready", 32'(byte_ready), 32'd0);
    check("rst_hold", 32'(cpu_hold), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Full-rate load of three words.
    check_gap = 1'b1; last_wr_cyc = -1; wr_cnt1 = 0;
    run_load(1, 3, 0, 1'b0);
    wait_done(1, "t1");
    check("t1_done_lat", 32'(cyc - last_wr_cyc), 32'd1);
    @(negedge clk);
    check("t1_done_pulse", 32'(done), 32'd0);
    check("t1_hold_off", 32'(cpu_hold), 32'd0);
    check("t1_wrcnt", 32'(wr_cnt1), 32'd3);
    check_gap = 1'b0;

    // Same load with ByteValid low every other cycle.
    wr_cnt1 = 0;
    run_load(1, 3, 1, 1'b0);
    wait_done(1, "t2");
    @(negedge clk);
    check("t2_wrcnt", 32'(wr_cnt1), 32'd3);

    // Zero-length load and oversized request.
    wr_cnt1 = 0;
    pulse_start(1, 0);
    check("t3_zero_ready", 32'(byte_ready), 32'd0);
    wait_done(1, "t3");
    @(negedge clk);
    check("t3_zero_wrcnt", 32'(wr_cnt1), 32'd0);
    pulse_start(1, 257);
    check("t3_err", 32'(error), 32'd1);
    check("t3_err_hold", 32'(cpu_hold), 32'd0);
    @(negedge clk);
    check("t3_err_pulse", 32'(error), 32'd0);
    check("t3_err_idle", 32'(byte_ready), 32'd0);

    // Busy-time Start is ignored.
    wr_cnt1 = 0;
    run_load(1, 3, 0, 1'b1);
    wait_done(1, "t6");
    @(negedge clk);
    check("t6_wrcnt", 32'(wr_cnt1), 32'd3);

    // Reset after two bytes of word 1.
    wr_cnt1 = 0;
    pulse_start(1, 3);
    for (int b = 0; b < 4; b++) begin
      logic [31:0] wd;
      wd = words[0];
      send_byte(1, wd[31-8*b -: 8], 0, (b == 3), {32'd0, wd});
    end
    send_byte(1, 8'h08, 0, 1'b0, 64'd0);
    send_byte(1, 8'h00, 0, 1'b0, 64'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t5_wren", 32'(mem_wr_en), 32'd0);
    check("t5_addr", mem_address, 32'd0);
    check("t5_hold", 32'(cpu_hold), 32'd0);
    check("t5_ready", 32'(byte_ready), 32'd0);
    repeat (4) @(negedge clk);
    check("t5_no_done", 32'(done), 32'd0);
    check("t5_wrcnt", 32'(wr_cnt1), 32'd1);
    check("t5_q_empty", 32'(q1.size()), 32'd0);
    wr_cnt1 = 0;
    run_load(1, 1, 0, 1'b0);
    wait_done(1, "t5b");
    @(negedge clk);
    check("t5b_wrcnt", 32'(wr_cnt1), 32'd1);

    // Full RAM on the 2-bit instance, then an extra byte must be refused.
    wr_cnt2 = 0;
    run_load(2, 4, 0, 1'b0);
    wait_done(2, "t4");
    @(negedge clk);
    check("t4_wrcnt", 32'(wr_cnt2), 32'd4);
    d2_valid = 1'b1; d2_data = 8'hAA;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_extra_ready", 32'(d2_ready), 32'd0);
    end
    d2_valid = 1'b0;
    check("t4_extra_wrcnt", 32'(wr_cnt2), 32'd4);
    pulse_start(2, 5);
    check("t4_err", 32'(d2_error), 32'd1);

    check("end_q1", 32'(q1.size()), 32'd0);
    check("end_q2", 32'(q2.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
